// File: rtl/amber_cap_xfer_seq.sv
// amber_cap_xfer_seq: sequences 10-word capability record CLD/CST transfers between the CR file and DMEM.
// Define AMBER_CAPXFER_BOUNDS_EN to enable the code-3 window bounds check.
`ifndef CR_PERM_R_BIT
`define CR_PERM_R_BIT 0
`endif
`ifndef CR_PERM_W_BIT
`define CR_PERM_W_BIT 1
`endif
`ifndef CR_PERM_LC_BIT
`define CR_PERM_LC_BIT 2
`endif
`ifndef CR_PERM_SC_BIT
`define CR_PERM_SC_BIT 3
`endif

module amber_cap_xfer_seq #(
    parameter int DMEM_AW   = 16,
    parameter int REC_WORDS = 10
) (
    input  logic               iw_clk,
    input  logic               iw_rst,
    input  logic               iw_req_valid,
    output logic               ow_req_ready,
    input  logic               iw_req_op,
    input  logic [47:0]        iw_req_addr,
    input  logic [1:0]         iw_req_dst_cr,
    input  logic [47:0]        iw_win_base,
    input  logic [47:0]        iw_win_len,
    input  logic [23:0]        iw_win_perms,
    input  logic               iw_win_tag,
    input  logic [47:0]        iw_src_base,
    input  logic [47:0]        iw_src_len,
    input  logic [47:0]        iw_src_cur,
    input  logic [23:0]        iw_src_perms,
    input  logic [23:0]        iw_src_attr,
    input  logic               iw_src_tag,
    input  logic               iw_flush,
    output logic               ow_mem_en,
    output logic               ow_mem_we,
    output logic [DMEM_AW-1:0] ow_mem_addr,
    output logic [23:0]        ow_mem_wdata,
    input  logic [23:0]        iw_mem_rdata,
    output logic               ow_cr_we,
    output logic [1:0]         ow_cr_idx,
    output logic [47:0]        ow_cr_base,
    output logic [47:0]        ow_cr_len,
    output logic [47:0]        ow_cr_cur,
    output logic [23:0]        ow_cr_perms,
    output logic [23:0]        ow_cr_attr,
    output logic               ow_cr_tag,
    output logic               ow_done,
    output logic               ow_fault,
    output logic [2:0]         ow_fault_code
);

`ifdef AMBER_CAPXFER_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif
    localparam logic [3:0] LAST = 4'(REC_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_LDRAIN, S_STORE, S_DONE, S_FAULT
    } state_t;

    state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, nxt;
    logic [47:0] addr_q, addr_d;
    logic [1:0]  dst_q, dst_d;
    logic [REC_WORDS-1:0][23:0] word_q, word_d;
    logic        cap_q, cap_d;
    logic [3:0]  cap_idx_q, cap_idx_d;
    logic        ready_q, ready_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [DMEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [23:0] mem_wdata_q, mem_wdata_d;
    logic        cr_we_q, cr_we_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic [2:0]  code_q, code_d;

    logic        perm_ok, oob;
    logic [2:0]  chk_code;
    logic        unused_perm_bits;

    assign unused_perm_bits = ^iw_win_perms;

    // Accept-time window checks; bounds use 49 bits so a wrapping record faults.
    always_comb begin
        perm_ok = iw_req_op
            ? (iw_win_perms[`CR_PERM_W_BIT] & iw_win_perms[`CR_PERM_SC_BIT])
            : (iw_win_perms[`CR_PERM_R_BIT] & iw_win_perms[`CR_PERM_LC_BIT]);
        oob = BOUNDS_EN &&
              (({1'b0, iw_req_addr} < {1'b0, iw_win_base}) ||
               (({1'b0, iw_req_addr} + 49'(REC_WORDS)) >
                ({1'b0, iw_win_base} + {1'b0, iw_win_len})));
        if (!iw_win_tag)   chk_code = 3'd1;
        else if (!perm_ok) chk_code = 3'd2;
        else if (oob)      chk_code = 3'd3;
        else               chk_code = 3'd0;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        dst_d       = dst_q;
        word_d      = word_q;
        cap_d       = 1'b0;
        cap_idx_d   = cap_idx_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cr_we_d     = 1'b0;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        code_d      = code_q;
        nxt         = cnt_q + 4'd1;
        if (cap_q) word_d[cap_idx_q] = iw_mem_rdata;
        unique case (state_q)
            S_IDLE: begin
                if (iw_req_valid) begin
                    addr_d = iw_req_addr;
                    cnt_d  = 4'd0;
                    if (chk_code != 3'd0) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                        code_d  = chk_code;
                    end else if (iw_req_op) begin
                        state_d     = S_STORE;
                        word_d[0]   = iw_src_base[23:0];
                        word_d[1]   = iw_src_base[47:24];
                        word_d[2]   = iw_src_len[23:0];
                        word_d[3]   = iw_src_len[47:24];
                        word_d[4]   = iw_src_cur[23:0];
                        word_d[5]   = iw_src_cur[47:24];
                        word_d[6]   = iw_src_perms;
                        word_d[7]   = iw_src_attr;
                        word_d[8]   = {23'd0, iw_src_tag};
                        word_d[9]   = 24'd0;
                        mem_en_d    = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = DMEM_AW'(iw_req_addr);
                        mem_wdata_d = iw_src_base[23:0];
                    end else begin
                        state_d    = S_LOAD;
                        dst_d      = iw_req_dst_cr;
                        mem_en_d   = 1'b1;
                        mem_addr_d = DMEM_AW'(iw_req_addr);
                    end
                end
            end
            S_LOAD: begin
                if (iw_flush) begin
                    state_d = S_IDLE;
                end else begin
                    cap_d     = 1'b1;
                    cap_idx_d = cnt_q;
                    if (cnt_q == LAST) begin
                        state_d = S_LDRAIN;
                    end else begin
                        cnt_d      = nxt;
                        mem_en_d   = 1'b1;
                        mem_addr_d = DMEM_AW'(addr_q + 48'(nxt));
                    end
                end
            end
            S_LDRAIN: begin
                if (iw_flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    cr_we_d = 1'b1;
                    done_d  = 1'b1;
                end
            end
            S_STORE: begin
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d       = nxt;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = DMEM_AW'(addr_q + 48'(nxt));
                    mem_wdata_d = word_q[nxt];
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 48'd0;
            dst_q       <= 2'd0;
            word_q      <= '0;
            cap_q       <= 1'b0;
            cap_idx_q   <= 4'd0;
            ready_q     <= 1'b1;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 24'd0;
            cr_we_q     <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            code_q      <= 3'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            dst_q       <= dst_d;
            word_q      <= word_d;
            cap_q       <= cap_d;
            cap_idx_q   <= cap_idx_d;
            ready_q     <= ready_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cr_we_q     <= cr_we_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            code_q      <= code_d;
        end
    end

    assign ow_req_ready  = ready_q;
    assign ow_mem_en     = mem_en_q;
    assign ow_mem_we     = mem_we_q;
    assign ow_mem_addr   = mem_addr_q;
    assign ow_mem_wdata  = mem_wdata_q;
    assign ow_cr_we      = cr_we_q;
    assign ow_cr_idx     = dst_q;
    assign ow_cr_base    = {word_q[1], word_q[0]};
    assign ow_cr_len     = {word_q[3], word_q[2]};
    assign ow_cr_cur     = {word_q[5], word_q[4]};
    assign ow_cr_perms   = word_q[6];
    assign ow_cr_attr    = word_q[7];
    assign ow_cr_tag     = word_q[8][0];
    assign ow_done       = done_q;
    assign ow_fault      = fault_q;
    assign ow_fault_code = code_q;

endmodule
